// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the frame-RAM port A arbiter: default sizes,
// arbiter FSM state type and an index-width helper.
package ram_port_arbiter_pkg;

    localparam int NUM_REQ_DEF   = 2;
    localparam int ADDR_SIZE_DEF = 16;
    localparam int DATA_SIZE_DEF = 32;
    localparam int MAX_BURST_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    // Width needed to hold an index 0..n-1 (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side bus of the port A arbiter: per-requester valid/ready
// request handshake plus per-requester read-response pulses on a shared
// read-data bus.
interface ram_port_arbiter_if
    import ram_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int DATA_SIZE = DATA_SIZE_DEF
);

    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0]                req_ready;
    logic [NUM_REQ-1:0]                req_we;
    logic [NUM_REQ-1:0][ADDR_SIZE-1:0] req_addr;
    logic [NUM_REQ-1:0][DATA_SIZE-1:0] req_wdata;
    logic [NUM_REQ-1:0]                rsp_valid;
    logic [DATA_SIZE-1:0]              rsp_rdata;

    // Requester side
    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata
    );

    // Arbiter side
    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        output rsp_rdata
    );

endinterface

// File: rtl/ram_port_arbiter_rr_picker.sv
// Combinational round-robin picker: finds the first set bit of 'valid'
// starting at index 'start' and wrapping around. Rotates the vector so that
// 'start' lands at bit 0, priority-encodes the lowest set bit, then adds the
// start index back modulo NUM_REQ.
module ram_port_arbiter_rr_picker
    import ram_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IDX_W   = idx_width(NUM_REQ_DEF)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   start,
    output logic               found,
    output logic [IDX_W-1:0]   winner
);

    localparam logic [IDX_W:0] NUM_L = (IDX_W + 1)'(NUM_REQ);

    logic [2*NUM_REQ-1:0] dbl_s;
    logic [NUM_REQ-1:0]   rot_s;
    logic [IDX_W-1:0]     off_s;
    logic [IDX_W:0]       sum_s;

    // Rotate, priority-encode the lowest set bit, un-rotate modulo NUM_REQ.
    always_comb begin
        dbl_s = {valid, valid};
        rot_s = NUM_REQ'(dbl_s >> start);
        off_s = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            off_s = rot_s[k] ? IDX_W'(k) : off_s;
        end
        found  = |rot_s;
        sum_s  = {1'b0, start} + {1'b0, off_s};
        winner = (sum_s >= NUM_L) ? IDX_W'(sum_s - NUM_L) : sum_s[IDX_W-1:0];
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Port A arbiter for the dual-port frame RAM. Requesters compete for port A
// through a round-robin grant with bounded bursts: an owner keeps the port
// for up to MAX_BURST consecutive accepts, after which the grant rotates
// without a bubble. The RAM is driven combinationally in the accept cycle;
// read data returns one cycle later on the shared response bus.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 arb_en,
    ram_port_arbiter_if.slave    req_bus,
    output logic [ADDR_SIZE-1:0] ram_addr_A,
    output logic [DATA_SIZE-1:0] ram_data_in_A,
    output logic                 ram_w_e_A,
    output logic                 ram_r_e_A,
    input  logic [DATA_SIZE-1:0] ram_data_out_A
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int BW    = $clog2(MAX_BURST + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [BW-1:0]    MAX_L    = BW'(MAX_BURST);
    localparam logic [BW-1:0]    ONE_L    = BW'(1);

    arb_state_t         state_r, state_nxt_s;
    logic [IDX_W-1:0]   owner_r, owner_nxt_s;
    logic [IDX_W-1:0]   rr_ptr_r, rr_ptr_nxt_s;
    logic [BW-1:0]      burst_cnt_r, burst_cnt_nxt_s;
    logic [NUM_REQ-1:0] rsp_valid_r;

    logic               arb_ok_s;
    logic [IDX_W-1:0]   pick_start_s;
    logic               pick_found_s;
    logic [IDX_W-1:0]   pick_winner_s;
    logic               xfer_s;
    logic [IDX_W-1:0]   sel_s;
    logic               sel_we_s;
    logic [NUM_REQ-1:0] grant_s;

    // Next index modulo NUM_REQ.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] res;
        if (idx == LAST_IDX) begin
            res = '0;
        end else begin
            res = idx + IDX_W'(1);
        end
        return res;
    endfunction

    // No accepts while reset is asserted, so port A stays quiet during reset.
    assign arb_ok_s = arb_en & nrst;

    // In IDLE the search starts at rr_ptr; while owning it starts just past
    // the owner so the owner itself is considered last.
    assign pick_start_s = (state_r == OWN) ? wrap_inc(owner_r) : rr_ptr_r;

    ram_port_arbiter_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .valid  (req_bus.req_valid),
        .start  (pick_start_s),
        .found  (pick_found_s),
        .winner (pick_winner_s)
    );

    // Arbitration FSM: decides the accept for this cycle and the next owner state.
    always_comb begin
        state_nxt_s     = state_r;
        owner_nxt_s     = owner_r;
        rr_ptr_nxt_s    = rr_ptr_r;
        burst_cnt_nxt_s = burst_cnt_r;
        xfer_s          = 1'b0;
        sel_s           = owner_r;
        case (state_r)
            IDLE: begin
                if (arb_ok_s && pick_found_s) begin
                    xfer_s          = 1'b1;
                    sel_s           = pick_winner_s;
                    owner_nxt_s     = pick_winner_s;
                    burst_cnt_nxt_s = ONE_L;
                    rr_ptr_nxt_s    = wrap_inc(pick_winner_s);
                    state_nxt_s     = OWN;
                end else begin
                    state_nxt_s     = IDLE;
                end
            end
            OWN: begin
                if (arb_ok_s && req_bus.req_valid[owner_r] && (burst_cnt_r < MAX_L)) begin
                    xfer_s          = 1'b1;
                    sel_s           = owner_r;
                    burst_cnt_nxt_s = burst_cnt_r + ONE_L;
                    state_nxt_s     = OWN;
                end else if (arb_ok_s && pick_found_s) begin
                    // Rotate in the same cycle; may land on the owner again.
                    xfer_s          = 1'b1;
                    sel_s           = pick_winner_s;
                    owner_nxt_s     = pick_winner_s;
                    burst_cnt_nxt_s = ONE_L;
                    rr_ptr_nxt_s    = wrap_inc(pick_winner_s);
                    state_nxt_s     = OWN;
                end else begin
                    state_nxt_s     = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // One-hot grant vector from the selected requester.
    always_comb begin
        grant_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_s[i] = xfer_s & (sel_s == IDX_W'(i));
        end
    end

    assign sel_we_s = req_bus.req_we[sel_s];

    // Request mux onto RAM port A; everything is zero when nothing transfers.
    always_comb begin
        ram_addr_A    = '0;
        ram_data_in_A = '0;
        ram_w_e_A     = 1'b0;
        ram_r_e_A     = 1'b0;
        if (xfer_s) begin
            ram_addr_A    = req_bus.req_addr[sel_s];
            ram_data_in_A = req_bus.req_wdata[sel_s];
            ram_w_e_A     = sel_we_s;
            ram_r_e_A     = ~sel_we_s;
        end else begin
            ram_addr_A    = '0;
            ram_data_in_A = '0;
            ram_w_e_A     = 1'b0;
            ram_r_e_A     = 1'b0;
        end
    end

    // FSM state and ownership bookkeeping registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r     <= IDLE;
            owner_r     <= '0;
            rr_ptr_r    <= '0;
            burst_cnt_r <= '0;
        end else begin
            state_r     <= state_nxt_s;
            owner_r     <= owner_nxt_s;
            rr_ptr_r    <= rr_ptr_nxt_s;
            burst_cnt_r <= burst_cnt_nxt_s;
        end
    end

    // Response register: a read accepted now is answered next cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rsp_valid_r <= '0;
        end else if (xfer_s && !sel_we_s) begin
            rsp_valid_r <= grant_s;
        end else begin
            rsp_valid_r <= '0;
        end
    end

    assign req_bus.req_ready = grant_s;
    assign req_bus.rsp_valid = rsp_valid_r;
    // RAM output is already registered; gate it so the bus is idle between responses.
    assign req_bus.rsp_rdata = (|rsp_valid_r) ? ram_data_out_A : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed testbench for ram_port_arbiter: a 2-requester instance with
// bursts of 4 backed by a small RAM model, and a 3-requester instance with
// bursts of 1 for wrap-around and sole-requester cases.
module tb_ram_port_arbiter;

    typedef struct {
        logic        arb_en;
        logic [2:0]  valid;
        logic [2:0]  we;
        logic [2:0]  ready;
        logic        we_a;
        logic        re_a;
        logic [15:0] addr;
        logic [31:0] din;
        logic [2:0]  rsp;
        logic [31:0] rdata;
    } vec_t;

    logic clk = 1'b0;
    logic nrst;
    logic arb_en2, arb_en3;

    logic [15:0] addr_a2, addr_a3;
    logic [31:0] din_a2, din_a3;
    logic        we_a2, we_a3, re_a2, re_a3;
    logic [31:0] dout2, dout3;

    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;
    logic [31:0] mem2 [0:255];

    int n_checks = 0;
    int n_fail   = 0;

    vec_t v2 [23];
    vec_t v3 [10];

    always #5 clk = ~clk;

    ram_port_arbiter_if #(.NUM_REQ(2), .ADDR_SIZE(16), .DATA_SIZE(32)) bus2 ();
    ram_port_arbiter_if #(.NUM_REQ(3), .ADDR_SIZE(16), .DATA_SIZE(32)) bus3 ();

    ram_port_arbiter #(.NUM_REQ(2), .ADDR_SIZE(16), .DATA_SIZE(32), .MAX_BURST(4)) dut2 (
        .clk            (clk),
        .nrst           (nrst),
        .arb_en         (arb_en2),
        .req_bus        (bus2),
        .ram_addr_A     (addr_a2),
        .ram_data_in_A  (din_a2),
        .ram_w_e_A      (we_a2),
        .ram_r_e_A      (re_a2),
        .ram_data_out_A (dout2)
    );

    ram_port_arbiter #(.NUM_REQ(3), .ADDR_SIZE(16), .DATA_SIZE(32), .MAX_BURST(1)) dut3 (
        .clk            (clk),
        .nrst           (nrst),
        .arb_en         (arb_en3),
        .req_bus        (bus3),
        .ram_addr_A     (addr_a3),
        .ram_data_in_A  (din_a3),
        .ram_w_e_A      (we_a3),
        .ram_r_e_A      (re_a3),
        .ram_data_out_A (dout3)
    );

    // Frame RAM model for dut2: registered read, one-cycle latency.
    always @(posedge clk) begin
        if (load_en) begin
            mem2[load_addr] <= load_data;
        end else if (we_a2) begin
            mem2[addr_a2[7:0]] <= din_a2;
        end
        if (re_a2) begin
            dout2 <= mem2[addr_a2[7:0]];
        end
    end

    // Address-tagged read data for dut3.
    always @(posedge clk) begin
        if (re_a3) begin
            dout3 <= {16'hC0DE, addr_a3};
        end
    end

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic run2(input vec_t v, input int k);
        @(negedge clk);
        arb_en2         = v.arb_en;
        bus2.req_valid  = v.valid[1:0];
        bus2.req_we     = v.we[1:0];
        #1;
        chk("d2_ready", k, 32'(bus2.req_ready), 32'(v.ready));
        chk("d2_we_a",  k, 32'(we_a2), 32'(v.we_a));
        chk("d2_re_a",  k, 32'(re_a2), 32'(v.re_a));
        if (v.we_a || v.re_a) chk("d2_addr", k, 32'(addr_a2), 32'(v.addr));
        if (v.we_a) chk("d2_din", k, din_a2, v.din);
        chk("d2_rsp", k, 32'(bus2.rsp_valid), 32'(v.rsp));
        if (v.rsp != 3'd0) chk("d2_rdata", k, bus2.rsp_rdata, v.rdata);
    endtask

    task automatic run3(input vec_t v, input int k);
        @(negedge clk);
        arb_en3         = v.arb_en;
        bus3.req_valid  = v.valid;
        bus3.req_we     = v.we;
        #1;
        chk("d3_ready", k, 32'(bus3.req_ready), 32'(v.ready));
        chk("d3_we_a",  k, 32'(we_a3), 32'(v.we_a));
        chk("d3_re_a",  k, 32'(re_a3), 32'(v.re_a));
        if (v.we_a || v.re_a) chk("d3_addr", k, 32'(addr_a3), 32'(v.addr));
        chk("d3_rsp", k, 32'(bus3.rsp_valid), 32'(v.rsp));
        if (v.rsp != 3'd0) chk("d3_rdata", k, bus3.rsp_rdata, v.rdata);
    endtask

    initial begin
        //             en valid   we      ready   wea   rea   addr      din           rsp     rdata
        v2[0]  = '{1'b1, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0000, 32'h0,        3'd0, 32'h0};
        v2[1]  = '{1'b1, 3'd1, 3'd0, 3'd1, 1'b0, 1'b1, 16'h0010, 32'h0,        3'd0, 32'h0};
        v2[2]  = '{1'b1, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0000, 32'h0,        3'd1, 32'hDEADBEEF};
        v2[3]  = '{1'b1, 3'd2, 3'd2, 3'd2, 1'b1, 1'b0, 16'h00FF, 32'h12345678, 3'd0, 32'h0};
        v2[4]  = '{1'b1, 3'd2, 3'd0, 3'd2, 1'b0, 1'b1, 16'h00FF, 32'h0,        3'd0, 32'h0};
        v2[5]  = '{1'b1, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0000, 32'h0,        3'd2, 32'h12345678};
        v2[6]  = '{1'b1, 3'd3, 3'd0, 3'd1, 1'b0, 1'b1, 16'h0010, 32'h0,        3'd0, 32'h0};
        v2[7]  = '{1'b1, 3'd3, 3'd0, 3'd1, 1'b0, 1'b1, 16'h0010, 32'h0,        3'd1, 32'hDEADBEEF};
        v2[8]  = '{1'b1, 3'd3, 3'd0, 3'd1, 1'b0, 1'b1, 16'h0010, 32'h0,        3'd1, 32'hDEADBEEF};
        v2[9]  = '{1'b1, 3'd3, 3'd0, 3'd1, 1'b0, 1'b1, 16'h0010, 32'h0,        3'd1, 32'hDEADBEEF};
        v2[10] = '{1'b1, 3'd3, 3'd0, 3'd2, 1'b0, 1'b1, 16'h00FF, 32'h0,        3'd1, 32'hDEADBEEF};
        v2[11] = '{1'b1, 3'd3, 3'd0, 3'd2, 1'b0, 1'b1, 16'h00FF, 32'h0,        3'd2, 32'h12345678};
        v2[12] = '{1'b1, 3'd3, 3'd0, 3'd2, 1'b0, 1'b1, 16'h00FF, 32'h0,        3'd2, 32'h12345678};
        v2[13] = '{1'b1, 3'd3, 3'd0, 3'd2, 1'b0, 1'b1, 16'h00FF, 32'h0,        3'd2, 32'h12345678};
        v2[14] = '{1'b1, 3'd3, 3'd0, 3'd1, 1'b0, 1'b1, 16'h0010, 32'h0,        3'd2, 32'h12345678};
        v2[15] = '{1'b1, 3'd3, 3'd0, 3'd1, 1'b0, 1'b1, 16'h0010, 32'h0,        3'd1, 32'hDEADBEEF};
        v2[16] = '{1'b0, 3'd3, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0000, 32'h0,        3'd1, 32'hDEADBEEF};
        v2[17] = '{1'b0, 3'd3, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0000, 32'h0,        3'd0, 32'h0};
        v2[18] = '{1'b0, 3'd3, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0000, 32'h0,        3'd0, 32'h0};
        v2[19] = '{1'b1, 3'd3, 3'd0, 3'd2, 1'b0, 1'b1, 16'h00FF, 32'h0,        3'd0, 32'h0};
        v2[20] = '{1'b1, 3'd3, 3'd0, 3'd2, 1'b0, 1'b1, 16'h00FF, 32'h0,        3'd2, 32'h12345678};
        v2[21] = '{1'b1, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0000, 32'h0,        3'd2, 32'h12345678};
        v2[22] = '{1'b1, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0000, 32'h0,        3'd0, 32'h0};

        v3[0]  = '{1'b1, 3'd4, 3'd0, 3'd4, 1'b0, 1'b1, 16'h0102, 32'h0, 3'd0, 32'h0};
        v3[1]  = '{1'b1, 3'd1, 3'd0, 3'd1, 1'b0, 1'b1, 16'h0100, 32'h0, 3'd4, 32'hC0DE0102};
        v3[2]  = '{1'b1, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0000, 32'h0, 3'd1, 32'hC0DE0100};
        v3[3]  = '{1'b1, 3'd7, 3'd0, 3'd2, 1'b0, 1'b1, 16'h0101, 32'h0, 3'd0, 32'h0};
        v3[4]  = '{1'b1, 3'd7, 3'd0, 3'd4, 1'b0, 1'b1, 16'h0102, 32'h0, 3'd2, 32'hC0DE0101};
        v3[5]  = '{1'b1, 3'd7, 3'd0, 3'd1, 1'b0, 1'b1, 16'h0100, 32'h0, 3'd4, 32'hC0DE0102};
        v3[6]  = '{1'b1, 3'd2, 3'd0, 3'd2, 1'b0, 1'b1, 16'h0101, 32'h0, 3'd1, 32'hC0DE0100};
        v3[7]  = '{1'b1, 3'd2, 3'd0, 3'd2, 1'b0, 1'b1, 16'h0101, 32'h0, 3'd2, 32'hC0DE0101};
        v3[8]  = '{1'b1, 3'd2, 3'd0, 3'd2, 1'b0, 1'b1, 16'h0101, 32'h0, 3'd2, 32'hC0DE0101};
        v3[9]  = '{1'b1, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0000, 32'h0, 3'd2, 32'hC0DE0101};

        // Reset with requests pending and the RAM preloaded.
        nrst            = 1'b0;
        arb_en2         = 1'b1;
        arb_en3         = 1'b1;
        bus2.req_valid  = 2'b11;
        bus2.req_we     = 2'b00;
        bus2.req_addr[0]  = 16'h0010;
        bus2.req_addr[1]  = 16'h00FF;
        bus2.req_wdata[0] = 32'h0;
        bus2.req_wdata[1] = 32'h12345678;
        bus3.req_valid  = 3'b000;
        bus3.req_we     = 3'b000;
        for (int i = 0; i < 3; i++) begin
            bus3.req_addr[i]  = 16'h0100 + 16'(i);
            bus3.req_wdata[i] = 32'h0;
        end
        load_en   = 1'b1;
        load_addr = 8'h10;
        load_data = 32'hDEADBEEF;

        @(negedge clk);
        load_en = 1'b0;
        #1;
        chk("rst_ready", 0, 32'(bus2.req_ready), 32'h0);
        chk("rst_we_a",  0, 32'(we_a2), 32'h0);
        chk("rst_re_a",  0, 32'(re_a2), 32'h0);
        chk("rst_addr",  0, 32'(addr_a2), 32'h0);
        chk("rst_din",   0, din_a2, 32'h0);
        chk("rst_rsp",   0, 32'(bus2.rsp_valid), 32'h0);

        @(negedge clk);
        nrst           = 1'b1;
        bus2.req_valid = 2'b00;

        for (int k = 0; k < 23; k++) begin
            run2(v2[k], k);
        end

        // Reset mid-burst with a read response in flight.
        @(negedge clk);
        bus2.req_valid = 2'b01;
        #1;
        chk("mid_ready", 0, 32'(bus2.req_ready), 32'h1);
        @(negedge clk);
        #1;
        chk("mid_rsp_pre", 0, 32'(bus2.rsp_valid), 32'h1);
        nrst = 1'b0;
        #1;
        chk("mid_rsp",   0, 32'(bus2.rsp_valid), 32'h0);
        chk("mid_ready", 1, 32'(bus2.req_ready), 32'h0);
        chk("mid_re_a",  0, 32'(re_a2), 32'h0);
        chk("mid_addr",  0, 32'(addr_a2), 32'h0);
        @(negedge clk);
        nrst           = 1'b1;
        bus2.req_valid = 2'b11;
        #1;
        chk("post_rst_ready", 0, 32'(bus2.req_ready), 32'h1);
        @(negedge clk);
        bus2.req_valid = 2'b00;
        #1;
        chk("post_rst_rsp",   0, 32'(bus2.rsp_valid), 32'h1);
        chk("post_rst_rdata", 0, bus2.rsp_rdata, 32'hDEADBEEF);

        for (int k = 0; k < 10; k++) begin
            run3(v3[k], k);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
